// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel, decode-side
// valid/ready channel, and the control inputs (halt, redirect).
//   master : the fetch queue (drives imem_req/imem_addr and out_*)
//   slave  : the surroundings (memory, decode, branch unit)
interface instr_fetch_queue_if;
    localparam int unsigned W = 16;

    logic         halt;
    logic         redirect;
    logic [W-1:0] redirect_pc;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_ack;
    logic [W-1:0] imem_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_ir;
    logic [W-1:0] out_pc;

    modport master (
        input  halt, redirect, redirect_pc, imem_ack, imem_data, out_ready,
        output imem_req, imem_addr, out_valid, out_ir, out_pc
    );

    modport slave (
        output halt, redirect, redirect_pc, imem_ack, imem_data, out_ready,
        input  imem_req, imem_addr, out_valid, out_ir, out_pc
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one word fetch at a time over req/ack,
// buffers {instruction, pc} pairs in a DEPTH-entry FIFO and hands them to
// decode over valid/ready. A redirect flushes the queue and restarts fetch;
// a request already in flight is drained and its data dropped.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high
//   bus   - instr_fetch_queue_if.master (imem req/ack, out valid/ready,
//           halt, redirect/redirect_pc)
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_fetch_queue_if.master    bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] pc;
    } entry_t;

    state_t        state_q, state_d;
    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [15:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [DEPTH];

    logic          push_c;
    logic          pop_c;
    logic          valid_c;
    entry_t        wr_entry_c;

    assign valid_c    = (count_q != '0);
    assign pop_c      = valid_c && bus.out_ready && !bus.redirect;
    assign wr_entry_c = '{ir: bus.imem_data, pc: fetch_pc_q};

    // Fetch FSM: issue, wait for ack, drain a request orphaned by a redirect
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        push_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc;
                end else if (!bus.halt && (count_q < CW'(DEPTH))) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc;
                    if (bus.imem_ack) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (bus.imem_ack) begin
                    push_c     = 1'b1;
                    fetch_pc_d = fetch_pc_q + 16'd1;
                    req_d      = 1'b0;
                    state_d    = IDLE;
                end
            end
            DRAIN: begin
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc;
                end
                if (bus.imem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Queue bookkeeping; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State and storage registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            if (push_c) begin
                mem_q[wr_ptr_q] <= wr_entry_c;
            end
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.out_valid = valid_c;
    assign bus.out_ir    = mem_q[rd_ptr_q].ir;
    assign bus.out_pc    = mem_q[rd_ptr_q].pc;
endmodule
